// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI command / memory arbitration controller:
// command encodings, the tx return FSM states and the requester identities.
package spi_mem_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_HOLD = 2'd2
    } tx_state_t;

    // Requester identity; the value doubles as the index into req/gnt vectors.
    typedef enum logic {
        REQ_SPI  = 1'b0,
        REQ_HOST = 1'b1
    } req_t;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter. Bit 0 is the SPI slot, bit 1 the host.
// The grant is combinational so the winner reaches the memory in the same
// cycle; the remembered last winner only breaks ties.
module mem_rr_arb
    import spi_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_t last_gnt_r;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_r == REQ_HOST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the most recent winner; HOST after reset so SPI wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= REQ_HOST;
        end else if (gnt[0]) begin
            last_gnt_r <= REQ_SPI;
        end else if (gnt[1]) begin
            last_gnt_r <= REQ_HOST;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI command controller: decodes the 10-bit SPI slave word stream into
// address/data commands with post-incrementing pointers, shares the single
// memory port with a host through a round-robin arbiter, and returns SPI
// read data over the tx_data/tx_valid handshake.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_gnt,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 host_rvalid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 err_ovf,
    output logic                 err_seq
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = {ADDR_SIZE{1'b0}};
    localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    // Pointer advance with explicit wrap at the top of the memory.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        if (p == LAST_ADDR) begin
            return ZERO_ADDR;
        end else begin
            return p + ONE_ADDR;
        end
    endfunction

    logic                 rx_valid_q_r;
    logic                 rx_edge_s;
    logic [1:0]           cmd_s;
    logic [7:0]           payload_s;

    logic                 slot_valid_r;
    logic                 slot_we_r;
    logic [ADDR_SIZE-1:0] slot_addr_r;
    logic [DATA_W-1:0]    slot_data_r;

    logic [ADDR_SIZE-1:0] wr_ptr_r;
    logic [ADDR_SIZE-1:0] rd_ptr_r;
    logic                 rd_addr_seen_r;

    logic                 drop_s;
    logic                 load_s;
    logic                 seq_err_s;

    logic [1:0]           req_s;
    logic [1:0]           gnt_s;
    logic                 spi_gnt_s;
    logic                 host_rd_q_r;

    tx_state_t            tx_state_r;
    tx_state_t            tx_state_nxt_s;
    logic                 tx_valid_nxt_s;
    logic                 tx_load_s;

    assign rx_edge_s = rx_valid & ~rx_valid_q_r;
    assign cmd_s     = rx_data[9:8];
    assign payload_s = rx_data[7:0];

    // A level held on rx_valid must only be accepted once: remember last cycle's level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q_r <= 1'b0;
        end else begin
            rx_valid_q_r <= rx_valid;
        end
    end

    // Data-command acceptance: a slot still occupied (even if granted now) or a read still in flight drops the command.
    always_comb begin
        drop_s    = 1'b0;
        load_s    = 1'b0;
        seq_err_s = 1'b0;
        if (rx_edge_s && (cmd_s == CMD_WR_DATA)) begin
            drop_s = slot_valid_r;
            load_s = ~slot_valid_r;
        end else if (rx_edge_s && (cmd_s == CMD_RD_DATA)) begin
            drop_s    = slot_valid_r | (tx_state_r == TX_WAIT);
            load_s    = ~drop_s;
            seq_err_s = ~drop_s & ~rd_addr_seen_r;
        end else begin
            drop_s    = 1'b0;
            load_s    = 1'b0;
            seq_err_s = 1'b0;
        end
    end

    // Pending SPI access slot: loaded by an accepted data command, freed on its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 1'b0;
            slot_we_r    <= 1'b0;
            slot_addr_r  <= ZERO_ADDR;
            slot_data_r  <= {DATA_W{1'b0}};
        end else if (load_s) begin
            slot_valid_r <= 1'b1;
            slot_we_r    <= (cmd_s == CMD_WR_DATA);
            slot_addr_r  <= (cmd_s == CMD_WR_DATA) ? wr_ptr_r : rd_ptr_r;
            slot_data_r  <= payload_s;
        end else if (spi_gnt_s) begin
            slot_valid_r <= 1'b0;
        end else begin
            slot_valid_r <= slot_valid_r;
        end
    end

    // Address pointers: an address command overrides a same-cycle post-increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= ZERO_ADDR;
            rd_ptr_r       <= ZERO_ADDR;
            rd_addr_seen_r <= 1'b0;
        end else begin
            if (rx_edge_s && (cmd_s == CMD_WR_ADDR)) begin
                wr_ptr_r <= payload_s[ADDR_SIZE-1:0];
            end else if (spi_gnt_s && slot_we_r) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rx_edge_s && (cmd_s == CMD_RD_ADDR)) begin
                rd_ptr_r       <= payload_s[ADDR_SIZE-1:0];
                rd_addr_seen_r <= 1'b1;
            end else if (spi_gnt_s && !slot_we_r) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // The host request is masked in reset so no access can be strobed while rst_n is low.
    assign req_s     = {host_req & rst_n, slot_valid_r};
    assign spi_gnt_s = gnt_s[0];
    assign host_gnt  = gnt_s[1];

    mem_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    // Memory port mux: the winner drives the memory in its grant cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ZERO_ADDR;
        mem_wdata = {DATA_W{1'b0}};
        if (gnt_s[0]) begin
            mem_en    = 1'b1;
            mem_we    = slot_we_r;
            mem_addr  = slot_addr_r;
            mem_wdata = slot_data_r;
        end else if (gnt_s[1]) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Host read return: memory data is valid the cycle after the grant, registered out one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rd_q_r <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= {DATA_W{1'b0}};
        end else begin
            host_rd_q_r <= gnt_s[1] & ~host_we;
            host_rvalid <= host_rd_q_r;
            if (host_rd_q_r) begin
                host_rdata <= mem_rdata;
            end else begin
                host_rdata <= host_rdata;
            end
        end
    end

    // tx return FSM: wait one cycle for read data, then hold it until the next command edge.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_valid_nxt_s = tx_valid;
        tx_load_s      = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_valid_nxt_s = 1'b0;
                if (spi_gnt_s && !slot_we_r) begin
                    tx_state_nxt_s = TX_WAIT;
                end else begin
                    tx_state_nxt_s = TX_IDLE;
                end
            end
            TX_WAIT: begin
                tx_load_s      = 1'b1;
                tx_valid_nxt_s = 1'b1;
                tx_state_nxt_s = TX_HOLD;
            end
            TX_HOLD: begin
                if (rx_edge_s) begin
                    tx_valid_nxt_s = 1'b0;
                    tx_state_nxt_s = TX_IDLE;
                end else begin
                    tx_valid_nxt_s = 1'b1;
                    tx_state_nxt_s = TX_HOLD;
                end
            end
            default: begin
                tx_valid_nxt_s = 1'b0;
                tx_state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // tx FSM state and registered tx outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_valid   <= tx_valid_nxt_s;
            if (tx_load_s) begin
                tx_data <= mem_rdata;
            end else begin
                tx_data <= tx_data;
            end
        end
    end

    // Error pulses appear the cycle after the offending command edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            err_ovf <= drop_s;
            err_seq <= seq_err_s;
        end
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- Command controller and arbiter between the SPI slave's 10-bit receive word stream and a single-port data memory.
- Decodes address and data commands, and keeps write/read address pointers that post-increment.
- Shares the memory port round-robin with a local host port.
- Returns read data to the slave over the tx_data/tx_valid handshake.

Parameters:
- ADDR_SIZE, 8, memory address width.
- MEM_DEPTH, 256, number of words; must equal 2**ADDR_SIZE.
- DATA_W, 8, memory word width; must be 8 to match the slave payload.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_data  in  10  slave word; [9:8] command, [7:0] payload.
- rx_valid  in  1  slave word valid; level, may stay high for several cycles.
- tx_data  out  8  read data to the slave.
- tx_valid  out  1  read data valid to the slave.
- host_req  in  1  host access request; held until grant.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle grant pulse.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host read data valid, one-cycle pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.
- err_ovf  out  1  pulse: SPI command dropped because the previous SPI op is still pending.
- err_seq  out  1  pulse: RD_DATA issued with no RD_ADDR since reset.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; wr_ptr=rd_ptr=0; rd_addr_seen=0; spi pending slot empty; tx FSM=TX_IDLE; last_gnt=HOST, so SPI wins the first conflict. An in-flight access is abandoned; mem_en falls immediately.
- Command accept: exactly once per rx_valid rising edge, detected from rx_valid registered one cycle. A level that stays high is not re-accepted.
- 00 WR_ADDR: wr_ptr<=payload. No memory access.
- 01 WR_DATA: load pending slot {we=1, addr=wr_ptr, data=payload}.
- 10 RD_ADDR: rd_ptr<=payload; rd_addr_seen<=1. No memory access.
- 11 RD_DATA: load pending slot {we=0, addr=rd_ptr}. If rd_addr_seen=0, pulse err_seq and still read from rd_ptr (0 after reset).
- Pointer post-increment: at the grant cycle, mod MEM_DEPTH (255 wraps to 0).
- Drop rule: if a WR_DATA or RD_DATA edge arrives while the slot is still occupied, or tx FSM=TX_WAIT for an RD_DATA, pulse err_ovf the next cycle. The command is dropped and pointers are unchanged.
- Address commands are never dropped.
- Arbitration, each cycle with candidates = {spi slot valid, host_req}:
  - One candidate: it wins.
  - Both: the one not equal to last_gnt wins.
  - The winner drives mem_en=1, mem_we, mem_addr, mem_wdata that same cycle (combinational from the registered slot or host inputs).
  - host_gnt pulses in the same cycle as a host win; last_gnt updates.
  - The SPI slot clears on its grant.
  - At most one access per cycle, so throughput is one access per clock.
- Read return: a read granted in cycle N samples mem_rdata at the edge ending N+1.
  - Host read: host_rdata/host_rvalid registered, visible cycle N+2.
  - SPI read: goes to the tx FSM.
- tx FSM:
  - TX_IDLE: SPI read granted -> TX_WAIT.
  - TX_WAIT: on capture, tx_data<=mem_rdata, tx_valid<=1 -> TX_HOLD.
  - TX_HOLD: tx_valid and tx_data held stable. The next accepted command edge of any kind clears tx_valid the following cycle -> TX_IDLE. That command is processed normally in the same cycle.
  - tx_valid is 0 in TX_IDLE and TX_WAIT.
- Simultaneous events: a command edge and a grant of the previous slot in the same cycle count as occupied, so the new command is dropped (err_ovf). Host and SPI writes to the same address in consecutive cycles land in grant order.

Decomposition:
- Package spi_mem_pkg: command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; tx FSM enum {TX_IDLE, TX_WAIT, TX_HOLD}; requester enum {REQ_SPI, REQ_HOST}.
- One sub-module, mem_rr_arb: two-requester round-robin arbiter (req[1:0] in, one-hot gnt out, last_gnt register).
- Command decode and the tx FSM stay in the top module.

Test Plan:
- WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x3C -> mem writes addr 0x10=0xA5, 0x11=0x3C; wr_ptr ends at 0x12.
- RD_ADDR 0x10, then RD_DATA -> mem read of 0x10; tx_valid=1 with tx_data=0xA5 two cycles after grant; held until next command edge, then 0 one cycle later; rd_ptr=0x11.
- WR_ADDR 0xFF, WR_DATA 0x01, WR_DATA 0x02 -> writes at 0xFF then 0x00 (wrap).
- host_req held as a read of 0x20 while SPI WR_DATA pending, last_gnt=HOST -> SPI granted first; host_gnt next cycle; host_rvalid two cycles later with the stored word.
- RD_DATA right after reset -> err_seq pulse; read from address 0. Second WR_DATA edge while slot blocked by continuous host_req won turn -> err_ovf pulse; dropped word never written.
- rst_n low during TX_WAIT -> tx_valid, mem_en 0 immediately; after release, RD_DATA without RD_ADDR raises err_seq again.
